// File: rtl/hack_cpu_mc_pkg.sv
// ---------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the multi-cycle Hack CPU core:
//   - state_t      : FSM states of the core (FETCH, EXEC, MEMWAIT)
//   - *_BIT        : bit positions of the C-instruction fields
//   - JMP_ALWAYS   : jump field value of an unconditional jump
// ---------------------------------------------------------------------------
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    // C-instruction field bit indices (identical for every WIDTH)
    localparam int A_BIT  = 12;
    localparam int ZX_BIT = 11;
    localparam int NX_BIT = 10;
    localparam int ZY_BIT = 9;
    localparam int NY_BIT = 8;
    localparam int F_BIT  = 7;
    localparam int NO_BIT = 6;
    localparam int DA_BIT = 5;
    localparam int DD_BIT = 4;
    localparam int DM_BIT = 3;
    localparam int JLT_BIT = 2;
    localparam int JEQ_BIT = 1;
    localparam int JGT_BIT = 0;

    localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/hack_cpu_mc_alu.sv
// ---------------------------------------------------------------------------
// hack_alu
// Combinational Hack ALU at WIDTH bits.
// Ports:
//   x, y                 in  WIDTH  operands (x = D, y = A or M)
//   zx, nx, zy, ny, f, no in 1      standard Hack control bits
//   out                  out WIDTH  result (modulo 2^WIDTH)
//   zr                   out 1      out == 0
//   ng                   out 1      out is negative (MSB set)
// ---------------------------------------------------------------------------
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] w_x_z;
    logic [WIDTH-1:0] w_x_n;
    logic [WIDTH-1:0] w_y_z;
    logic [WIDTH-1:0] w_y_n;
    logic [WIDTH-1:0] w_f;

    assign w_x_z = zx ? '0 : x;
    assign w_x_n = nx ? ~w_x_z : w_x_z;
    assign w_y_z = zy ? '0 : y;
    assign w_y_n = ny ? ~w_y_z : w_y_z;
    assign w_f   = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    assign out   = no ? ~w_f : w_f;
    assign zr    = (out == '0);
    assign ng    = out[WIDTH-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// ---------------------------------------------------------------------------
// hack_cpu_mc
// Multi-cycle Hack CPU core with handshaked instruction fetch and data read,
// a retired-instruction counter and a sticky halt detector (self-jump).
// Ports:
//   clock        in  1       clock, all state on rising edge
//   reset        in  1       asynchronous, active-low
//   instruction  in  WIDTH   instruction word at pc
//   instr_valid  in  1       instruction is valid for current pc
//   inM          in  WIDTH   data read value
//   inM_valid    in  1       inM valid for the outstanding read
//   readM        out 1       read request, held until inM_valid
//   writeM       out 1       one-cycle write strobe
//   outM         out WIDTH   write data (ALU result)
//   addressM     out ADDR_W  data address (low bits of A)
//   pc           out ADDR_W  fetch address
//   retired      out CNT_W   completed instruction count (wraps)
//   halted       out 1       sticky self-jump flag
// ---------------------------------------------------------------------------
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  instruction,
    input  logic              instr_valid,
    input  logic [WIDTH-1:0]  inM,
    input  logic              inM_valid,
    output logic              readM,
    output logic              writeM,
    output logic [WIDTH-1:0]  outM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_ir;
    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   r_retired;
    logic               r_halted;

    logic               w_is_a;
    logic               w_is_c;
    logic               w_fetch_uses_m;
    logic [WIDTH-1:0]   w_alu_y;
    logic [WIDTH-1:0]   w_alu_out;
    logic               w_zr;
    logic               w_ng;
    logic               w_jump;
    logic               w_self_jump;

    // Decode of the latched instruction
    assign w_is_a = ~r_ir[WIDTH-1];
    assign w_is_c = r_ir[WIDTH-1] & (&r_ir[WIDTH-2:13]);

    // Decided on the incoming word so MEMWAIT can start right after FETCH
    assign w_fetch_uses_m = instruction[WIDTH-1] & (&instruction[WIDTH-2:13])
                          & instruction[A_BIT];

    assign w_alu_y = r_ir[A_BIT] ? r_m : r_a;

    hack_alu #(.WIDTH(WIDTH)) u_alu (
        .x   (r_d),
        .y   (w_alu_y),
        .zx  (r_ir[ZX_BIT]),
        .nx  (r_ir[NX_BIT]),
        .zy  (r_ir[ZY_BIT]),
        .ny  (r_ir[NY_BIT]),
        .f   (r_ir[F_BIT]),
        .no  (r_ir[NO_BIT]),
        .out (w_alu_out),
        .zr  (w_zr),
        .ng  (w_ng)
    );

    assign w_jump = w_is_c & ((r_ir[JLT_BIT] & w_ng)
                            | (r_ir[JEQ_BIT] & w_zr)
                            | (r_ir[JGT_BIT] & ~w_ng & ~w_zr));

    // Unconditional jump to its own address: the program can never leave
    assign w_self_jump = w_is_c && (r_ir[2:0] == JMP_ALWAYS)
                      && (r_a[ADDR_W-1:0] == r_pc);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        readM        = 1'b0;
        writeM       = 1'b0;
        case (r_state)
            FETCH: begin
                if (!r_halted && instr_valid) begin
                    w_state_next = w_fetch_uses_m ? MEMWAIT : EXEC;
                end
            end
            MEMWAIT: begin
                readM = 1'b1;
                if (inM_valid) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                writeM       = w_is_c & r_ir[DM_BIT];
                w_state_next = FETCH;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a       <= '0;
            r_d       <= '0;
            r_m       <= '0;
            r_ir      <= '0;
            r_pc      <= '0;
            r_retired <= '0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!r_halted && instr_valid) begin
                        r_ir <= instruction;
                    end
                end
                MEMWAIT: begin
                    if (inM_valid) begin
                        r_m <= inM;
                    end
                end
                EXEC: begin
                    r_retired <= r_retired + CNT_ONE;
                    // Jump target and write address both use A before update
                    r_pc <= w_jump ? r_a[ADDR_W-1:0] : (r_pc + PC_ONE);
                    if (w_is_a) begin
                        r_a <= {1'b0, r_ir[WIDTH-2:0]};
                    end else if (w_is_c) begin
                        if (r_ir[DA_BIT]) begin
                            r_a <= w_alu_out;
                        end
                        if (r_ir[DD_BIT]) begin
                            r_d <= w_alu_out;
                        end
                        if (w_self_jump) begin
                            r_halted <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign outM     = w_alu_out;
    assign addressM = r_a[ADDR_W-1:0];
    assign pc       = r_pc;
    assign retired  = r_retired;
    assign halted   = r_halted;

endmodule

// File: tb/tb_hack_cpu_mc.sv
module tb_hack_cpu_mc;

    logic        clock;
    logic        reset;

    // 16-bit core
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] inM;
    logic        inM_valid;
    logic        readM;
    logic        writeM;
    logic [15:0] outM;
    logic [14:0] addressM;
    logic [14:0] pc;
    logic [31:0] retired;
    logic        halted;

    // 24-bit core
    logic [23:0] instruction2;
    logic        instr_valid2;
    logic [23:0] inM2;
    logic        inM_valid2;
    logic        readM2;
    logic        writeM2;
    logic [23:0] outM2;
    logic [19:0] addressM2;
    logic [19:0] pc2;
    logic [31:0] retired2;
    logic        halted2;

    int n_checks;
    int n_fail;

    // values captured during the EXEC cycle of the last instruction
    int          rd_cnt;
    int          wr_cnt;
    logic        exec_wr;
    logic        exec_rd;
    logic [23:0] exec_out;
    logic [19:0] exec_addr;

    hack_cpu_mc dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .inM         (inM),
        .inM_valid   (inM_valid),
        .readM       (readM),
        .writeM      (writeM),
        .outM        (outM),
        .addressM    (addressM),
        .pc          (pc),
        .retired     (retired),
        .halted      (halted)
    );

    hack_cpu_mc #(.WIDTH(24), .ADDR_W(20), .CNT_W(32)) dut24 (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction2),
        .instr_valid (instr_valid2),
        .inM         (inM2),
        .inM_valid   (inM_valid2),
        .readM       (readM2),
        .writeM      (writeM2),
        .outM        (outM2),
        .addressM    (addressM2),
        .pc          (pc2),
        .retired     (retired2),
        .halted      (halted2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one instruction to the 16-bit core, starting in FETCH.
    task automatic run_instr(input logic [15:0] ins, input int wait_n, input logic [15:0] mdata);
        rd_cnt = 0;
        wr_cnt = 0;
        instruction = ins;
        instr_valid = 1'b1;
        if (writeM) wr_cnt++;
        tick();
        instr_valid = 1'b0;
        if (ins[15:13] == 3'b111 && ins[12]) begin
            for (int i = 0; i < wait_n; i++) begin
                if (readM) rd_cnt++;
                if (writeM) wr_cnt++;
                tick();
            end
            inM = mdata;
            inM_valid = 1'b1;
            if (readM) rd_cnt++;
            tick();
            inM_valid = 1'b0;
        end
        exec_rd   = readM;
        exec_wr   = writeM;
        exec_out  = {8'h00, outM};
        exec_addr = {5'h00, addressM};
        if (writeM) wr_cnt++;
        tick();
    endtask

    // Issue one non-memory-read instruction to the 24-bit core.
    task automatic run2(input logic [23:0] ins);
        instruction2 = ins;
        instr_valid2 = 1'b1;
        tick();
        instr_valid2 = 1'b0;
        exec_wr   = writeM2;
        exec_out  = outM2;
        exec_addr = addressM2;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b0;
        instruction = '0;
        instr_valid = 1'b0;
        inM = '0;
        inM_valid = 1'b0;
        instruction2 = '0;
        instr_valid2 = 1'b0;
        inM2 = '0;
        inM_valid2 = 1'b0;

        // 1. reset state, then @5
        tick();
        tick();
        check_val("rst_pc", 32'(pc), 32'd0);
        check_val("rst_retired", retired, 32'd0);
        check_val("rst_readM", 32'(readM), 32'd0);
        check_val("rst_writeM", 32'(writeM), 32'd0);
        check_val("rst_outM", 32'(outM), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        reset = 1'b1;
        tick();
        run_instr(16'h0005, 0, 16'h0);
        check_val("t1_addressM", 32'(addressM), 32'd5);
        check_val("t1_pc", 32'(pc), 32'd1);
        check_val("t1_retired", retired, 32'd1);
        check_val("t1_no_write", 32'(wr_cnt), 32'd0);

        // 2. A=7, D=3, M=D+1, then AM=D+1 writes via the old A
        run_instr(16'h0003, 0, 16'h0);
        run_instr(16'hEC10, 0, 16'h0);   // D=A
        run_instr(16'h0007, 0, 16'h0);
        run_instr(16'hE7C8, 0, 16'h0);   // M=D+1
        check_val("t2_writeM_pulse", 32'(wr_cnt), 32'd1);
        check_val("t2_outM", 32'(exec_out), 32'd4);
        check_val("t2_addressM", 32'(exec_addr), 32'd7);
        check_val("t2_pc", 32'(pc), 32'd5);
        run_instr(16'hE7E8, 0, 16'h0);   // AM=D+1
        check_val("t2_am_addr_old", 32'(exec_addr), 32'd7);
        check_val("t2_am_a_new", 32'(addressM), 32'd4);

        // 3. D=M with 4 wait cycles
        run_instr(16'h0002, 0, 16'h0);
        run_instr(16'hFC10, 4, 16'h1234); // D=M
        check_val("t3_readM_cycles", 32'(rd_cnt), 32'd5);
        check_val("t3_readM_drop", 32'(exec_rd), 32'd0);
        check_val("t3_pc", 32'(pc), 32'd8);
        run_instr(16'hE308, 0, 16'h0);   // M=D
        check_val("t3_D_value", 32'(exec_out), 32'h1234);
        check_val("t3_write_addr", 32'(exec_addr), 32'd2);
        run_instr(16'hB008, 0, 16'h0);   // not a C-inst: NOP
        check_val("t3_nop_no_read", 32'(rd_cnt), 32'd0);
        check_val("t3_nop_no_write", 32'(wr_cnt), 32'd0);
        check_val("t3_nop_pc", 32'(pc), 32'd10);
        check_val("t3_nop_retired", retired, 32'd10);

        // 4. conditional jumps
        run_instr(16'hEA90, 0, 16'h0);   // D=0
        run_instr(16'h000A, 0, 16'h0);   // @10
        run_instr(16'hE302, 0, 16'h0);   // D;JEQ taken
        check_val("t4_jeq_taken", 32'(pc), 32'd10);
        run_instr(16'hEFD0, 0, 16'h0);   // D=1
        run_instr(16'hE302, 0, 16'h0);   // D;JEQ not taken
        check_val("t4_jeq_not", 32'(pc), 32'd12);
        run_instr(16'hEE90, 0, 16'h0);   // D=-1
        run_instr(16'hE304, 0, 16'h0);   // D;JLT taken
        check_val("t4_jlt_taken", 32'(pc), 32'd10);
        run_instr(16'hE301, 0, 16'h0);   // D;JGT not taken
        check_val("t4_jgt_not", 32'(pc), 32'd11);
        check_val("t4_retired", retired, 32'd18);

        // 5. jump elsewhere does not halt; self-jump at 20 does
        run_instr(16'h0013, 0, 16'h0);   // @19
        run_instr(16'hEA87, 0, 16'h0);   // 0;JMP
        check_val("t5_jmp_pc", 32'(pc), 32'd19);
        check_val("t5_not_halted", 32'(halted), 32'd0);
        run_instr(16'h0014, 0, 16'h0);   // @20
        run_instr(16'hEA87, 0, 16'h0);   // 0;JMP to self
        check_val("t5_halted", 32'(halted), 32'd1);
        check_val("t5_retired", retired, 32'd22);
        instruction = 16'h0005;
        instr_valid = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (writeM) wr_cnt++;
            if (readM) rd_cnt++;
        end
        instr_valid = 1'b0;
        check_val("t5_frozen_retired", retired, 32'd22);
        check_val("t5_frozen_pc", 32'(pc), 32'd20);
        check_val("t5_frozen_A", 32'(addressM), 32'd20);
        check_val("t5_frozen_strobes", 32'(wr_cnt + rd_cnt), 32'd0);
        check_val("t5_still_halted", 32'(halted), 32'd1);

        // 6. async reset during MEMWAIT
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_val("t6_halt_cleared", 32'(halted), 32'd0);
        run_instr(16'h0005, 0, 16'h0);
        instruction = 16'hFC10;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check_val("t6_readM_wait", 32'(readM), 32'd1);
        check_val("t6_pc_before", 32'(pc), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("t6_readM_async", 32'(readM), 32'd0);
        check_val("t6_pc_async", 32'(pc), 32'd0);
        check_val("t6_retired_async", retired, 32'd0);
        tick();
        reset = 1'b1;
        inM = 16'hFFFF;
        inM_valid = 1'b1;
        tick();
        tick();
        inM_valid = 1'b0;
        check_val("t6_late_inM_readM", 32'(readM), 32'd0);
        check_val("t6_late_inM_retired", retired, 32'd0);
        run_instr(16'h0005, 0, 16'h0);
        check_val("t6_resume_pc", 32'(pc), 32'd1);
        check_val("t6_resume_A", 32'(addressM), 32'd5);

        // 7. WIDTH=24, ADDR_W=20 core
        run2(24'h7FFFFF);
        check_val("w24_addressM", 32'(addressM2), 32'h000FFFFF);
        run2(24'hFFEC10);                // D=A
        run2(24'hFFE308);                // M=D
        check_val("w24_outM", 32'(exec_out), 32'h007FFFFF);
        check_val("w24_write", 32'(exec_wr), 32'd1);
        check_val("w24_write_addr", 32'(exec_addr), 32'h000FFFFF);
        run2(24'hFFEA87);                // 0;JMP to 0xFFFFF
        check_val("w24_jmp_pc", 32'(pc2), 32'h000FFFFF);
        check_val("w24_not_halted", 32'(halted2), 32'd0);
        run2(24'h000000);                // @0, pc wraps
        check_val("w24_pc_wrap", 32'(pc2), 32'd0);
        check_val("w24_retired", retired2, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
